// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch/timer slice:
//   - MODE_* : 2-bit operating mode codes (UP, DOWN, LOAD, HOLD)
//   - BCD_W  : width of one BCD digit
//   - run_state_t : run/stop state of the counter
//   - digit_max() : largest legal value of a digit given the radix mask
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   localparam int BCD_W = 4;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_LOAD = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   typedef enum logic {
      ST_STOPPED = 1'b0,
      ST_RUNNING = 1'b1
   } run_state_t;

   // A set mask bit turns the digit into a base-6 (0..5) digit, e.g. tens of seconds.
   function automatic logic [BCD_W-1:0] digit_max(input int idx, input logic [31:0] radix_mask);
      logic [BCD_W-1:0] m;
      if (((radix_mask >> idx) & 32'd1) != 32'd0) begin
         m = 4'd5;
      end else begin
         m = 4'd9;
      end
      return m;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// -----------------------------------------------------------------------------
// bcd_digit_cell
// One digit of the cascaded counter. Counts 0..MAX up or down when enabled and
// its carry/borrow input is set; carry_out doubles as borrow_out in down mode.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   en             global count enable (already excludes saturation)
//   up             1 = increment, 0 = decrement
//   load           load load_val (clamped to MAX) this cycle
//   load_val       preset digit value
//   carry_in       carry/borrow from the next lower digit
//   digit          registered digit value
//   carry_out      carry (up) or borrow (down) into the next higher digit
// -----------------------------------------------------------------------------
module bcd_digit_cell
   import stopwatch_pkg::*;
#(
   parameter logic [BCD_W-1:0] MAX = 4'd9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   input  logic             carry_in,
   output logic [BCD_W-1:0] digit,
   output logic             carry_out
);

   logic [BCD_W-1:0] digit_r;

   // Ripple carry/borrow: this digit rolls over exactly when it sits at its end value.
   assign carry_out = carry_in & (up ? (digit_r == MAX) : (digit_r == 4'd0));
   assign digit     = digit_r;

   // Digit register: load with clamp, or step with wrap at 0/MAX.
   always_ff @(posedge clk) begin
      if (reset) begin
         digit_r <= 4'd0;
      end else if (load) begin
         digit_r <= (load_val > MAX) ? MAX : load_val;
      end else if (en & carry_in) begin
         if (up) begin
            digit_r <= (digit_r == MAX) ? 4'd0 : digit_r + 4'd1;
         end else begin
            digit_r <= (digit_r == 4'd0) ? MAX : digit_r - 4'd1;
         end
      end else begin
         digit_r <= digit_r;
      end
   end

endmodule

// File: rtl/bcd_timer_core.sv
// -----------------------------------------------------------------------------
// bcd_timer_core
// N-digit cascaded BCD up/down counter with per-digit radix, saturate or wrap
// at the top, edge-detected start/stop and an optional lap (split) capture.
// Optional feature macro: LAP_CAPTURE_EN (lap register and frozen display).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   tick            one-cycle count strobe from the divider
//   start_stop      button level; rising edge toggles run state
//   mode            MODE_UP / MODE_DOWN / MODE_LOAD / MODE_HOLD
//   load_digits     preset value used in MODE_LOAD
//   lap_btn         lap request level (only with LAP_CAPTURE_EN)
//   digits          live count, digit i at [4i+3:4i]
//   display_digits  live count or frozen lap value
//   running         counting enabled
//   expired         one-cycle pulse after the terminal tick
//   lap_active      display_digits shows the frozen lap value
// -----------------------------------------------------------------------------
module bcd_timer_core
   import stopwatch_pkg::*;
#(
   parameter int                    NUM_DIGITS    = 4,
   parameter logic [NUM_DIGITS-1:0] RADIX_MASK    = '0,
   parameter bit                    STOP_AT_LIMIT = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tick,
   input  logic                          start_stop,
   input  logic [1:0]                    mode,
   input  logic [BCD_W*NUM_DIGITS-1:0]   load_digits,
   input  logic                          lap_btn,
   output logic [BCD_W*NUM_DIGITS-1:0]   digits,
   output logic [BCD_W*NUM_DIGITS-1:0]   display_digits,
   output logic                          running,
   output logic                          expired,
   output logic                          lap_active
);

   run_state_t                    state_r;
   logic                          ss_q_r;
   logic                          expired_r;
   logic [BCD_W*NUM_DIGITS-1:0]   digit_bus_s;
   logic [NUM_DIGITS:0]           carry_s;
   logic [NUM_DIGITS-1:0]         is_max_s;
   logic [NUM_DIGITS-1:0]         is_zero_s;
   logic                          carry_unused_s;
   logic mode_up_s, mode_down_s, mode_load_s;
   logic count_s, ss_rise_s, all_max_s, all_zero_s, upper_zero_s;
   logic down_end_s, terminal_s, hold_s, cell_en_s, stop_now_s;

   assign mode_up_s   = (mode == MODE_UP);
   assign mode_down_s = (mode == MODE_DOWN);
   assign mode_load_s = (mode == MODE_LOAD);
   assign ss_rise_s   = start_stop & ~ss_q_r;

   // Uses the pre-edge run state, so a tick coinciding with a start edge does not count.
   assign count_s    = tick & (state_r == ST_RUNNING) & (mode_up_s | mode_down_s);
   assign carry_s[0] = count_s;

   genvar i;
   generate
      for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
         localparam logic [BCD_W-1:0] MAX_C = digit_max(i, 32'(RADIX_MASK));
         bcd_digit_cell #(.MAX(MAX_C)) u_cell (
            .clk       (clk),
            .reset     (reset),
            .en        (cell_en_s),
            .up        (mode_up_s),
            .load      (mode_load_s),
            .load_val  (load_digits[BCD_W*i +: BCD_W]),
            .carry_in  (carry_s[i]),
            .digit     (digit_bus_s[BCD_W*i +: BCD_W]),
            .carry_out (carry_s[i+1])
         );
         assign is_max_s[i]  = (digit_bus_s[BCD_W*i +: BCD_W] == MAX_C);
         assign is_zero_s[i] = (digit_bus_s[BCD_W*i +: BCD_W] == 4'd0);
      end
   endgenerate

   // The final carry leaves the counter; terminal detection uses the digit flags instead.
   assign carry_unused_s = carry_s[NUM_DIGITS];

   // All digits above digit 0 are zero.
   always_comb begin
      upper_zero_s = 1'b1;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         upper_zero_s = upper_zero_s & is_zero_s[k];
      end
   end

   assign all_max_s  = &is_max_s;
   assign all_zero_s = &is_zero_s;
   // Down count ends on the tick that reaches zero; an already-zero count is treated the same.
   assign down_end_s = upper_zero_s & (digit_bus_s[BCD_W-1:0] <= 4'd1);
   assign terminal_s = count_s & (mode_up_s ? all_max_s : down_end_s);
   // Freeze the digits at saturation (up) or at zero (down, never wraps below zero).
   assign hold_s     = mode_up_s ? (all_max_s & STOP_AT_LIMIT) : all_zero_s;
   assign cell_en_s  = count_s & ~hold_s;
   assign stop_now_s = terminal_s & (mode_down_s | STOP_AT_LIMIT);

   // Run FSM, start/stop edge detector and expired pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_STOPPED;
         ss_q_r    <= 1'b0;
         expired_r <= 1'b0;
      end else begin
         ss_q_r    <= start_stop;
         expired_r <= terminal_s;
         if (mode_load_s) begin
            state_r <= ST_STOPPED;
         end else if (stop_now_s) begin
            state_r <= ST_STOPPED;
         end else if (ss_rise_s & (mode_up_s | mode_down_s)) begin
            case (state_r)
               ST_RUNNING: state_r <= ST_STOPPED;
               ST_STOPPED: state_r <= (mode_down_s & all_zero_s) ? ST_STOPPED : ST_RUNNING;
               default:    state_r <= ST_STOPPED;
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

   assign digits  = digit_bus_s;
   assign running = (state_r == ST_RUNNING);
   assign expired = expired_r;

`ifdef LAP_CAPTURE_EN
   logic                        lap_q_r;
   logic                        lap_active_r;
   logic [BCD_W*NUM_DIGITS-1:0] lap_reg_r;
   logic                        lap_rise_s;

   assign lap_rise_s = lap_btn & ~lap_q_r;

   // Lap capture: first edge while running freezes the display, next edge releases it.
   always_ff @(posedge clk) begin
      if (reset) begin
         lap_q_r      <= 1'b0;
         lap_active_r <= 1'b0;
         lap_reg_r    <= '0;
      end else begin
         lap_q_r <= lap_btn;
         if (mode_load_s) begin
            lap_active_r <= 1'b0;
         end else if (lap_rise_s & lap_active_r) begin
            lap_active_r <= 1'b0;
         end else if (lap_rise_s & (state_r == ST_RUNNING)) begin
            lap_active_r <= 1'b1;
            lap_reg_r    <= digit_bus_s;
         end else begin
            lap_active_r <= lap_active_r;
         end
      end
   end

   assign display_digits = lap_active_r ? lap_reg_r : digit_bus_s;
   assign lap_active     = lap_active_r;
`else
   logic lap_unused_s;
   assign lap_unused_s   = lap_btn;
   assign display_digits = digit_bus_s;
   assign lap_active     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timer_core.sv
// -----------------------------------------------------------------------------
// tb_bcd_timer_core
// Two instances share one stimulus stream: instance 0 is decimal and saturating,
// instance 1 has a base-6 digit 2 and wraps at the top. A reference model keeps
// each count as a plain integer in its mixed radix and converts to digits.
// -----------------------------------------------------------------------------
module tb_bcd_timer_core;
   import stopwatch_pkg::*;

   logic        clk = 1'b0;
   logic        reset, tick, start_stop, lap_btn;
   logic [1:0]  mode;
   logic [15:0] load_digits;
   logic [15:0] dig  [2];
   logic [15:0] disp [2];
   logic        run  [2];
   logic        expd [2];
   logic        lapa [2];

   always #5 clk = ~clk;

   bcd_timer_core #(.NUM_DIGITS(4), .RADIX_MASK(4'b0000), .STOP_AT_LIMIT(1'b1)) u_dut_a (
      .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .mode(mode),
      .load_digits(load_digits), .lap_btn(lap_btn), .digits(dig[0]),
      .display_digits(disp[0]), .running(run[0]), .expired(expd[0]), .lap_active(lapa[0]));

   bcd_timer_core #(.NUM_DIGITS(4), .RADIX_MASK(4'b0100), .STOP_AT_LIMIT(1'b0)) u_dut_b (
      .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .mode(mode),
      .load_digits(load_digits), .lap_btn(lap_btn), .digits(dig[1]),
      .display_digits(disp[1]), .running(run[1]), .expired(expd[1]), .lap_active(lapa[1]));

   localparam logic [3:0] MASK  [2] = '{4'b0000, 4'b0100};
   localparam bit         STOPP [2] = '{1'b1, 1'b0};

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_val    [2];
   bit          m_run    [2];
   bit          m_exp    [2];
   bit          m_lapact [2];
   logic [15:0] m_lapreg [2];
   bit          m_ssq, m_lapq;

   function automatic int dmax(input int k, input int d);
      logic [3:0] m;
      m = MASK[k];
      return m[d] ? 5 : 9;
   endfunction

   function automatic int maxval(input int k);
      int p = 1;
      for (int d = 0; d < 4; d++) p = p * (dmax(k, d) + 1);
      return p - 1;
   endfunction

   function automatic int to_val(input int k, input logic [15:0] nib);
      int v = 0;
      int w = 1;
      int n;
      for (int d = 0; d < 4; d++) begin
         n = int'(nib[4*d +: 4]);
         if (n > dmax(k, d)) n = dmax(k, d);
         v = v + n * w;
         w = w * (dmax(k, d) + 1);
      end
      return v;
   endfunction

   function automatic logic [15:0] to_dig(input int k, input int v);
      logic [15:0] r = 16'h0000;
      int x = v;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(x % (dmax(k, d) + 1));
         x = x / (dmax(k, d) + 1);
      end
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One clock: advance the model from the current inputs, then compare every output.
   task automatic step();
      int          nv  [2];
      bit          nr  [2];
      bit          ne  [2];
      bit          nla [2];
      logic [15:0] nlr [2];
      bit up, dn, cnt, rise, lrise;
      up    = (mode == MODE_UP);
      dn    = (mode == MODE_DOWN);
      rise  = start_stop & ~m_ssq;
      lrise = lap_btn & ~m_lapq;
      for (int k = 0; k < 2; k++) begin
         cnt    = tick & m_run[k] & (up | dn);
         nv[k]  = m_val[k];
         nr[k]  = m_run[k];
         ne[k]  = 1'b0;
         nla[k] = m_lapact[k];
         nlr[k] = m_lapreg[k];
         if (reset) begin
            nv[k] = 0; nr[k] = 1'b0; nla[k] = 1'b0; nlr[k] = 16'h0000;
         end else if (mode == MODE_LOAD) begin
            nv[k] = to_val(k, load_digits); nr[k] = 1'b0; nla[k] = 1'b0;
         end else begin
            if (cnt && up) begin
               if (m_val[k] == maxval(k)) begin
                  ne[k] = 1'b1;
                  if (STOPP[k]) nr[k] = 1'b0;
                  else nv[k] = 0;
               end else begin
                  nv[k] = m_val[k] + 1;
               end
            end else if (cnt && dn) begin
               if (m_val[k] <= 1) begin
                  nv[k] = 0; ne[k] = 1'b1; nr[k] = 1'b0;
               end else begin
                  nv[k] = m_val[k] - 1;
               end
            end
            if (rise && (up || dn)) nr[k] = m_run[k] ? 1'b0 : !(dn && m_val[k] == 0);
`ifdef LAP_CAPTURE_EN
            if (lrise) begin
               if (m_lapact[k]) nla[k] = 1'b0;
               else if (m_run[k]) begin
                  nla[k] = 1'b1;
                  nlr[k] = to_dig(k, m_val[k]);
               end
            end
`endif
         end
      end
      @(posedge clk);
      #1;
      m_ssq  = reset ? 1'b0 : start_stop;
      m_lapq = reset ? 1'b0 : lap_btn;
      for (int k = 0; k < 2; k++) begin
         m_val[k] = nv[k]; m_run[k] = nr[k]; m_exp[k] = ne[k];
         m_lapact[k] = nla[k]; m_lapreg[k] = nlr[k];
         check($sformatf("model dig%0d", k), int'(dig[k]), int'(to_dig(k, m_val[k])));
         check($sformatf("model run%0d", k), int'(run[k]), int'(m_run[k]));
         check($sformatf("model exp%0d", k), int'(expd[k]), int'(m_exp[k]));
         check($sformatf("model lap%0d", k), int'(lapa[k]), int'(m_lapact[k]));
         check($sformatf("model disp%0d", k), int'(disp[k]),
               int'(m_lapact[k] ? m_lapreg[k] : to_dig(k, m_val[k])));
      end
   endtask

   task automatic expect_out(input string name, input int k, input logic [15:0] d,
                             input bit r, input bit e);
      check($sformatf("%s dig%0d", name, k), int'(dig[k]), int'(d));
      check($sformatf("%s run%0d", name, k), int'(run[k]), int'(r));
      check($sformatf("%s exp%0d", name, k), int'(expd[k]), int'(e));
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1; step();
      start_stop = 1'b0; step();
   endtask

   task automatic pulse_lap();
      lap_btn = 1'b1; step();
      lap_btn = 1'b0; step();
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) step();
      tick = 1'b0;
   endtask

   task automatic load(input logic [15:0] v);
      mode = MODE_LOAD; load_digits = v; step();
   endtask

   typedef struct {
      logic [15:0] ld;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
   } ld_vec_t;

   initial begin
      ld_vec_t tbl [6];
      logic [15:0] rnd;
      tbl[0] = '{16'h1599, 16'h1599, 16'h1599};
      tbl[1] = '{16'hFFFF, 16'h9999, 16'h9599};
      tbl[2] = '{16'h0A7C, 16'h0979, 16'h0579};
      tbl[3] = '{16'h3456, 16'h3456, 16'h3456};
      tbl[4] = '{16'h0060, 16'h0060, 16'h0060};
      tbl[5] = '{16'h0600, 16'h0600, 16'h0500};

      reset = 1'b1; tick = 1'b0; start_stop = 1'b0; lap_btn = 1'b0;
      mode = MODE_HOLD; load_digits = 16'h0000;
      step();
      for (int k = 0; k < 2; k++) expect_out("reset", k, 16'h0000, 1'b0, 1'b0);
      reset = 1'b0;

      // count up ten ticks, then reset mid-run
      mode = MODE_UP;
      pulse_ss();
      ticks(10);
      for (int k = 0; k < 2; k++) expect_out("up10", k, 16'h0010, 1'b1, 1'b0);
      reset = 1'b1; tick = 1'b1; step(); tick = 1'b0;
      for (int k = 0; k < 2; k++) begin
         expect_out("midreset", k, 16'h0000, 1'b0, 1'b0);
         check($sformatf("midreset lap%0d", k), int'(lapa[k]), 0);
         check($sformatf("midreset disp%0d", k), int'(disp[k]), 0);
      end
      reset = 1'b0;

      // load clamping table
      for (int i = 0; i < 6; i++) begin
         load(tbl[i].ld);
         check($sformatf("loadtbl%0d a", i), int'(dig[0]), int'(tbl[i].exp_a));
         check($sformatf("loadtbl%0d b", i), int'(dig[1]), int'(tbl[i].exp_b));
      end

      // base-6 digit rollover
      load(16'h1599);
      mode = MODE_UP; pulse_ss(); ticks(1);
      expect_out("radix", 0, 16'h1600, 1'b1, 1'b0);
      expect_out("radix", 1, 16'h2000, 1'b1, 1'b0);

      // down to zero, expiry, further ticks ignored
      load(16'h0002);
      mode = MODE_DOWN; pulse_ss();
      tick = 1'b1; step(); step(); tick = 1'b0;
      for (int k = 0; k < 2; k++) expect_out("down0", k, 16'h0000, 1'b0, 1'b1);
      step();
      for (int k = 0; k < 2; k++) expect_out("down0 after", k, 16'h0000, 1'b0, 1'b0);
      ticks(3);
      for (int k = 0; k < 2; k++) expect_out("down0 more", k, 16'h0000, 1'b0, 1'b0);

      // top of range: saturate (a) versus wrap (b)
      load(16'h9999);
      mode = MODE_UP; pulse_ss(); ticks(1);
      expect_out("limit", 0, 16'h9999, 1'b0, 1'b1);
      expect_out("limit", 1, 16'h0000, 1'b1, 1'b1);
      step();
      expect_out("limit after", 0, 16'h9999, 1'b0, 1'b0);

      // start edge coincident with tick does not count
      load(16'h0042);
      mode = MODE_UP; start_stop = 1'b1; tick = 1'b1; step();
      for (int k = 0; k < 2; k++) expect_out("startedge", k, 16'h0042, 1'b1, 1'b0);
      start_stop = 1'b0; step(); tick = 1'b0;
      for (int k = 0; k < 2; k++) expect_out("startedge next", k, 16'h0043, 1'b1, 1'b0);
      load(16'h0000);
      mode = MODE_DOWN; pulse_ss();
      for (int k = 0; k < 2; k++) expect_out("down start at 0", k, 16'h0000, 1'b0, 1'b0);

      // lap capture
      load(16'h0123);
      mode = MODE_UP; pulse_ss(); pulse_lap();
      ticks(7);
      for (int k = 0; k < 2; k++) begin
         expect_out("lap run", k, 16'h0130, 1'b1, 1'b0);
`ifdef LAP_CAPTURE_EN
         check($sformatf("lap frozen disp%0d", k), int'(disp[k]), 16'h0123);
         check($sformatf("lap frozen act%0d", k), int'(lapa[k]), 1);
`else
         check($sformatf("lap off disp%0d", k), int'(disp[k]), 16'h0130);
         check($sformatf("lap off act%0d", k), int'(lapa[k]), 0);
`endif
      end
      pulse_lap();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("lap release disp%0d", k), int'(disp[k]), 16'h0130);
         check($sformatf("lap release act%0d", k), int'(lapa[k]), 0);
      end

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         tick  = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 7) == 0) start_stop = ~start_stop;
         if ($urandom_range(0, 5) == 0) lap_btn = ~lap_btn;
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 15))
               0, 1, 2, 3, 4, 5, 6:    mode = MODE_UP;
               7, 8, 9, 10, 11, 12:    mode = MODE_DOWN;
               13:                     mode = MODE_LOAD;
               default:                mode = MODE_HOLD;
            endcase
         end
         for (int d = 0; d < 4; d++) begin
            if ($urandom_range(0, 1) == 1) rnd[4*d +: 4] = 4'($urandom_range(8, 15));
            else rnd[4*d +: 4] = 4'($urandom_range(0, 2));
         end
         load_digits = rnd;
         step();
         if (mode == MODE_LOAD) mode = MODE_UP;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
